alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one 8-bit dataflow ALU between four requesters using a round-robin req/gnt/rsp handshake.
- Latches the winner's operands and opcode, and drives the ALU's 2-bit requester select (the same S[1:0] encoding used by the 4:1 muxes: 00→D0 … 11→D3).
- Pulses the ALU start, waits a fixed ALU latency, then returns result and carry to the winning requester.
- Sits between the requester ports and the ALU top level.

Parameters:
- WIDTH, 8, operand/result width.
- OPW, 3, ALU opcode width.
- ALU_LAT, 1, cycles from alu_start to a valid alu_result; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per requester; held until its gnt bit pulses
- req_a  input  4*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  4*WIDTH  operand B, same packing
- req_op  input  4*OPW  opcode, requester i at [i*OPW +: OPW]
- gnt  output  4  one-hot, one-cycle pulse: requester's operands captured
- sel  output  2  index of current winner; ALU/result mux select
- alu_a  output  WIDTH  latched operand A
- alu_b  output  WIDTH  latched operand B
- alu_op  output  OPW  latched opcode
- alu_start  output  1  one-cycle pulse launching the operation
- alu_result  input  WIDTH  ALU result, valid ALU_LAT cycles after alu_start
- alu_carry  input  1  ALU carry/borrow, valid with alu_result
- rsp_valid  output  4  one-hot, one-cycle pulse to the winner
- rsp_data  output  WIDTH  captured result; holds until next response
- rsp_carry  output  1  captured carry; holds until next response
- busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs are registered and reset to 0. The round-robin pointer last resets to 3, so requester 0 has first priority. State resets to IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit scanning (last+1) mod 4 upward with wrap.
  - On the clock edge, latch that requester's a/b/op into alu_a/alu_b/alu_op, set sel, then go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (1 cycle):
  - gnt[sel]=1 and alu_start=1; load the wait counter with ALU_LAT-1; go to WAIT.
- WAIT (ALU_LAT cycles):
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0, capture alu_result/alu_carry into rsp_data/rsp_carry and go to RESP.
- RESP (1 cycle):
  - rsp_valid[sel]=1; last ← sel.
  - Arbitrate in this same cycle using the updated pointer (last = sel). If any req is set, latch the new winner and go straight to ISSUE; otherwise go to IDLE.
- Latency:
  - Req sampled in IDLE at edge N → gnt/alu_start high in cycle N+1 → rsp_valid high in cycle N+2+ALU_LAT.
  - Back-to-back throughput: one operation per ALU_LAT+2 cycles.
- Handshake rules:
  - Requester keeps req and operands stable until its gnt pulse, and drops req in the cycle after gnt unless it has a new operation.
  - A req bit still high during RESP counts as a new request.
  - Operands are latched at selection, so requester changes after gnt do not affect the operation in flight.
  - Operand changes before gnt but after selection are not seen.
- Arbitration rules:
  - The round-robin pointer updates only in RESP; gnt never fires without a matching rsp_valid.
  - A req bit dropped after selection does not cancel the operation; it completes and responds.
- Outputs between operations:
  - alu_a/alu_b/alu_op/sel hold their last values outside ISSUE/WAIT.
  - gnt, alu_start and rsp_valid are 0 except in their single cycles.
- Reset mid-operation: immediate return to IDLE with all outputs at 0. The pending operation is discarded and no rsp_valid is emitted.
- Width rules: no arithmetic is done in the block. The wait counter is 4 bits; ALU_LAT outside 1..15 is a configuration error, flagged by a simulation-only assertion.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - WIDTH/OPW defaults and the ALU_LAT bounds;
  - ALU opcode constants (ADD etc.) used by the benches.
- One combinational sub-module, rr_pick4: inputs req[3:0] and last[1:0]; outputs any and idx[1:0]. It is used in both IDLE and RESP.

Test Plan:
- Single op, ALU_LAT=1: req=4'b0100, a2=8'h35, b2=8'h0A, op=ADD.
  → gnt=4'b0100 and alu_start one cycle after sampling.
  → rsp_valid=4'b0100, rsp_data=8'h3F, rsp_carry=0 three cycles after sampling.
- Fairness from reset: req=4'b1111 held and re-raised after each gnt.
  → grant order 0,1,2,3,0, one gnt every 3 cycles, no idle cycle between ops.
- Pointer starvation check: req0 and req2 both always asserted.
  → grants alternate 0,2,0,2; requesters 1 and 3 never granted.
- Latency and carry, ALU_LAT=3: a=8'hFF, b=8'h01, op=ADD.
  → rsp_valid exactly 5 cycles after sampling, rsp_data=8'h00, rsp_carry=1; busy high for those 5 cycles.
- Reset in WAIT: assert rst_n=0 mid-WAIT for one cycle.
  → all outputs 0 immediately, no rsp_valid.
  → with req=4'b1001 after release, first gnt goes to requester 0.
- Request drop: req1 falls the cycle after selection, before gnt.
  → gnt and rsp still delivered to requester 1 with the latched operands.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin ALU arbiter: FSM encoding,
// default widths, latency bounds and the ALU opcode set seen by requesters.
package alu_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int N_REQ       = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_OPW     = 3;
  localparam int CNT_W       = 4;
  localparam int ALU_LAT_MIN = 1;
  localparam int ALU_LAT_MAX = 15;

  localparam logic [DEF_OPW-1:0] OP_ADD = 3'd0;
  localparam logic [DEF_OPW-1:0] OP_SUB = 3'd1;
  localparam logic [DEF_OPW-1:0] OP_AND = 3'd2;
  localparam logic [DEF_OPW-1:0] OP_OR  = 3'd3;
  localparam logic [DEF_OPW-1:0] OP_XOR = 3'd4;

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request bit at or after (last+1) mod 4, with wrap.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] idx
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any = |req;
    idx = last;
    // Scan farthest offset first so the nearest requester after 'last' overwrites and wins.
    for (int k = 3; k >= 0; k--) begin
      if (req[last + 2'(k + 1)]) idx = last + 2'(k + 1);
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between four requesters: round-robin select, issue, fixed-latency
// wait, then a one-cycle response to the winner. All outputs are registered.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int OPW     = DEF_OPW,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  input  logic [4*OPW-1:0]     req_op,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OPW-1:0]       alu_op,
  output logic                 alu_start,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carry,
  output logic [3:0]           rsp_valid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_carry,
  output logic                 busy
);

  state_e             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               start_q, start_d;
  logic [3:0]         rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               busy_q, busy_d;

  logic               pick_any;
  logic [1:0]         pick_idx;
  logic [1:0]         pick_last;

  // In RESP the pointer is being advanced to sel this very cycle, so arbitrate
  // against the updated value to keep back-to-back operations fair.
  assign pick_last = (state_q == ST_RESP) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    start_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;

    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (state_q == ST_RESP) last_d = sel_q;
        state_d = ST_IDLE;
        if (pick_any) begin
          // Operands are captured at selection; later changes by the requester are ignored.
          sel_d   = pick_idx;
          a_d     = req_a[int'(pick_idx)*WIDTH +: WIDTH];
          b_d     = req_b[int'(pick_idx)*WIDTH +: WIDTH];
          op_d    = req_op[int'(pick_idx)*OPW +: OPW];
          gnt_d   = onehot4(pick_idx);
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = alu_result;
          rsp_carry_d = alu_carry;
          rsp_valid_d = onehot4(sel_q);
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'd3;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = busy_q;

`ifndef SYNTHESIS
  lat_range_a: assert property (@(posedge clk)
    (ALU_LAT >= ALU_LAT_MIN) && (ALU_LAT <= ALU_LAT_MAX))
    else $error("alu_rr_arbiter: ALU_LAT=%0d outside %0d..%0d", ALU_LAT, ALU_LAT_MIN, ALU_LAT_MAX);
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each driven by a small ALU model whose result is valid only ALU_LAT cycles after start.
module tb_alu_rr_arbiter;
  import alu_rr_arbiter_pkg::*;

  localparam int W    = 8;
  localparam int OW   = 3;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]    d1_req, d3_req;
  logic [4*W-1:0] d1_a, d1_b, d3_a, d3_b;
  logic [4*OW-1:0] d1_op, d3_op;
  logic [3:0]    d1_gnt, d3_gnt, d1_rsp_valid, d3_rsp_valid;
  logic [1:0]    d1_sel, d3_sel;
  logic [W-1:0]  d1_alu_a, d1_alu_b, d3_alu_a, d3_alu_b;
  logic [OW-1:0] d1_alu_op, d3_alu_op;
  logic          d1_start, d3_start, d1_carry, d3_carry;
  logic [W-1:0]  d1_result, d3_result, d1_rsp_data, d3_rsp_data;
  logic          d1_rsp_carry, d3_rsp_carry, d1_busy, d3_busy;

  alu_rr_arbiter #(.WIDTH(W), .OPW(OW), .ALU_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(d1_req), .req_a(d1_a), .req_b(d1_b), .req_op(d1_op),
    .gnt(d1_gnt), .sel(d1_sel), .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
    .alu_start(d1_start), .alu_result(d1_result), .alu_carry(d1_carry),
    .rsp_valid(d1_rsp_valid), .rsp_data(d1_rsp_data), .rsp_carry(d1_rsp_carry), .busy(d1_busy)
  );

  alu_rr_arbiter #(.WIDTH(W), .OPW(OW), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(d3_req), .req_a(d3_a), .req_b(d3_b), .req_op(d3_op),
    .gnt(d3_gnt), .sel(d3_sel), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
    .alu_start(d3_start), .alu_result(d3_result), .alu_carry(d3_carry),
    .rsp_valid(d3_rsp_valid), .rsp_data(d3_rsp_data), .rsp_carry(d3_rsp_carry), .busy(d3_busy)
  );

  function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Result is only meaningful in the cycle exactly LAT cycles after alu_start; otherwise junk.
  int lat_cnt1, lat_cnt3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  lat_cnt1 <= 0;
    else if (d1_start)                           lat_cnt1 <= 1;
    else if (lat_cnt1 != 0 && lat_cnt1 < LAT1)   lat_cnt1 <= lat_cnt1 + 1;
    else                                         lat_cnt1 <= 0;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  lat_cnt3 <= 0;
    else if (d3_start)                           lat_cnt3 <= 1;
    else if (lat_cnt3 != 0 && lat_cnt3 < LAT3)   lat_cnt3 <= lat_cnt3 + 1;
    else                                         lat_cnt3 <= 0;
  end
  always_comb begin
    {d1_carry, d1_result} = (lat_cnt1 == LAT1) ? alu_model(d1_alu_op, d1_alu_a, d1_alu_b) : 9'h1C3;
    {d3_carry, d3_result} = (lat_cnt3 == LAT3) ? alu_model(d3_alu_op, d3_alu_a, d3_alu_b) : 9'h1C3;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] fair_gnt[5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] fair_data[5] = '{8'h46, 8'hF0, 8'h30, 8'hA5, 8'h46};
  logic       fair_cy[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] starv_gnt[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  logic [3:0] rsp_seen;

  initial begin
    rst_n  = 1'b0;
    d1_req = '0; d1_a = '0; d1_b = '0; d1_op = '0;
    d3_req = '0; d3_a = '0; d3_b = '0; d3_op = '0;
    tick();

    // Reset state
    check("rst_gnt",    d1_gnt, 0);
    check("rst_sel",    d1_sel, 0);
    check("rst_start",  d1_start, 0);
    check("rst_rspv",   d1_rsp_valid, 0);
    check("rst_busy",   d1_busy, 0);
    check("rst_busy3",  d3_busy, 0);
    tick();
    rst_n = 1'b1;

    // Single op, ALU_LAT=1: requester 2 adds 35+0A
    d1_req = 4'b0100;
    d1_a[2*W +: W] = 8'h35; d1_b[2*W +: W] = 8'h0A; d1_op[2*OW +: OW] = OP_ADD;
    tick();
    check("t1_gnt",   d1_gnt, 4'b0100);
    check("t1_start", d1_start, 1);
    check("t1_sel",   d1_sel, 2);
    check("t1_alu_a", d1_alu_a, 8'h35);
    check("t1_busy",  d1_busy, 1);
    d1_req = '0;
    tick();
    check("t1_gnt_pulse", d1_gnt, 0);
    check("t1_rspv_early", d1_rsp_valid, 0);
    tick();
    check("t1_rspv",  d1_rsp_valid, 4'b0100);
    check("t1_data",  d1_rsp_data, 8'h3F);
    check("t1_carry", d1_rsp_carry, 0);
    tick();
    check("t1_rspv_pulse", d1_rsp_valid, 0);
    check("t1_idle",  d1_busy, 0);
    check("t1_hold",  d1_rsp_data, 8'h3F);

    // Fairness from reset: all four requesting continuously
    do_reset();
    d1_a = {8'hAA, 8'hF0, 8'h10, 8'h12};
    d1_b = {8'h0F, 8'h3C, 8'h20, 8'h34};
    d1_op = {OP_XOR, OP_AND, OP_SUB, OP_ADD};
    d1_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("fair_gnt%0d", k), d1_gnt, fair_gnt[k]);
      if (k == 4) d1_req = '0;
      tick();
      check($sformatf("fair_wait%0d", k), d1_gnt, 0);
      tick();
      check($sformatf("fair_rspv%0d", k), d1_rsp_valid, fair_gnt[k]);
      check($sformatf("fair_data%0d", k), d1_rsp_data, fair_data[k]);
      check($sformatf("fair_cy%0d", k),   d1_rsp_carry, fair_cy[k]);
    end
    tick();
    check("fair_idle", d1_busy, 0);

    // Starvation check: only requesters 0 and 2 asserted
    do_reset();
    d1_req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("starv_gnt%0d", k), d1_gnt, starv_gnt[k]);
      if (k == 3) d1_req = '0;
      tick();
      tick();
      check($sformatf("starv_rspv%0d", k), d1_rsp_valid, starv_gnt[k]);
    end
    tick();
    check("starv_idle", d1_busy, 0);

    // Latency and carry, ALU_LAT=3: FF+01 on requester 3
    d3_req = 4'b1000;
    d3_a[3*W +: W] = 8'hFF; d3_b[3*W +: W] = 8'h01; d3_op[3*OW +: OW] = OP_ADD;
    tick();
    check("l3_gnt",   d3_gnt, 4'b1000);
    check("l3_start", d3_start, 1);
    check("l3_busy0", d3_busy, 1);
    d3_req = '0;
    for (int w = 0; w < 3; w++) begin
      tick();
      check($sformatf("l3_busy_w%0d", w), d3_busy, 1);
      check($sformatf("l3_rspv_w%0d", w), d3_rsp_valid, 0);
    end
    tick();
    check("l3_rspv",  d3_rsp_valid, 4'b1000);
    check("l3_data",  d3_rsp_data, 8'h00);
    check("l3_carry", d3_rsp_carry, 1);
    check("l3_busy4", d3_busy, 1);
    tick();
    check("l3_idle",     d3_busy, 0);
    check("l3_rspv_off", d3_rsp_valid, 0);
    check("l3_cy_hold",  d3_rsp_carry, 1);
    check("l3_a_hold",   d3_alu_a, 8'hFF);
    check("l3_sel_hold", d3_sel, 3);

    // Reset asserted in WAIT: operation discarded
    d3_req = 4'b0010;
    d3_a[1*W +: W] = 8'h55; d3_b[1*W +: W] = 8'h11; d3_op[1*OW +: OW] = OP_AND;
    tick();
    check("rw_gnt", d3_gnt, 4'b0010);
    d3_req = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rw_busy",  d3_busy, 0);
    check("rw_sel",   d3_sel, 0);
    check("rw_alu_a", d3_alu_a, 0);
    check("rw_alu_b", d3_alu_b, 0);
    check("rw_data",  d3_rsp_data, 0);
    check("rw_carry", d3_rsp_carry, 0);
    check("rw_rspv",  d3_rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    rsp_seen = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      rsp_seen = rsp_seen | d3_rsp_valid;
    end
    check("rw_no_rsp", rsp_seen, 0);
    d3_req = 4'b1001;
    d3_a[0 +: W] = 8'h01; d3_b[0 +: W] = 8'h02; d3_op[0 +: OW] = OP_ADD;
    tick();
    check("rw_first_gnt", d3_gnt, 4'b0001);
    d3_req = '0;
    tick(); tick(); tick(); tick();
    check("rw_rspv", d3_rsp_valid, 4'b0001);
    check("rw_rdata", d3_rsp_data, 8'h03);
    tick();
    check("rw_idle", d3_busy, 0);

    // Request and operands dropped right after selection
    d1_req = 4'b0010;
    d1_a[1*W +: W] = 8'h20; d1_b[1*W +: W] = 8'h07; d1_op[1*OW +: OW] = OP_SUB;
    tick();
    d1_req = '0;
    d1_a[1*W +: W] = 8'hEE; d1_b[1*W +: W] = 8'hEE; d1_op[1*OW +: OW] = OP_OR;
    check("drop_gnt",   d1_gnt, 4'b0010);
    check("drop_alu_a", d1_alu_a, 8'h20);
    tick();
    tick();
    check("drop_rspv",  d1_rsp_valid, 4'b0010);
    check("drop_data",  d1_rsp_data, 8'h19);
    check("drop_carry", d1_rsp_carry, 0);
    tick();
    check("drop_idle",  d1_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
